time_cnt24: RTL and testbench

- BCD time-of-day core for the 24-hour clock; sits directly downstream of the 1 Hz enable / 2 Hz blink generator.
- Advances hh:mm:ss on each EN1HZ pulse.
- Provides a button-driven set mode (hours, then minutes) with blink flags for the display driver.
- All outputs are registered; this is the sole source of displayed time.

---
 rtl/time_cnt24.sv | 172 +++++++++++++++++
 tb/tb_time_cnt24.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/time_cnt24.sv
// time_cnt24 -- BCD 24-hour (or 12-hour) time-of-day core with button set mode.
//
// Counts hh:mm:ss on every EN1HZ pulse while running. MODE steps through
// RUN -> SET_H -> SET_M -> RUN; in the set states UP increments the selected
// field with its own wrap. All outputs are registered.
//
// Ports:
//   CLK      system clock
//   RST      synchronous reset, active-high
//   EN1HZ    one-cycle pulse, once per second
//   SIG2HZ   2 Hz blink source
//   MODE     one-cycle pulse, advances the set-mode FSM
//   UP       one-cycle pulse, increments the field being set
//   SEC      BCD seconds  {tens, units}, 00..59
//   MIN      BCD minutes  00..59
//   HOUR     BCD hours    00..HOURS_WRAP-1
//   BLINK_H  blank the hour digits
//   BLINK_M  blank the minute digits
//   DAYP     one-cycle pulse on the rollover to 00:00:00
module time_cnt24 #(
  parameter int HOURS_WRAP = 24
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN1HZ,
  input  logic       SIG2HZ,
  input  logic       MODE,
  input  logic       UP,
  output logic [7:0] SEC,
  output logic [7:0] MIN,
  output logic [7:0] HOUR,
  output logic       BLINK_H,
  output logic       BLINK_M,
  output logic       DAYP
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2
  } state_t;

  // Highest legal hour in BCD: 23 for a 24-hour clock, 11 for a 12-hour one.
  localparam logic [7:0] HOUR_MAX = (HOURS_WRAP == 12) ? 8'h11 : 8'h23;

  // Field index: 0 = seconds, 1 = minutes, 2 = hours.
  localparam logic [2:0][7:0] FIELD_MAX = {HOUR_MAX, 8'h59, 8'h59};

  state_t state_q, state_d;

  logic [7:0] sec_q, sec_d;
  logic [7:0] min_q, min_d;
  logic [7:0] hour_q, hour_d;
  logic       blink_h_q, blink_h_d;
  logic       blink_m_q, blink_m_d;
  logic       dayp_q, dayp_d;

  logic [2:0][7:0] field_cur;
  logic [2:0][7:0] field_inc;
  logic [2:0]      field_wrap;

  assign field_cur = {hour_q, min_q, sec_q};

  // One BCD incrementer per field; each reports whether it wrapped to 00.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_bcd_inc
      always_comb begin
        field_wrap[gi] = 1'b0;
        if (field_cur[gi] == FIELD_MAX[gi]) begin
          field_inc[gi]  = 8'h00;
          field_wrap[gi] = 1'b1;
        end else if (field_cur[gi][3:0] == 4'd9) begin
          field_inc[gi] = {field_cur[gi][7:4] + 4'd1, 4'd0};
        end else begin
          field_inc[gi] = {field_cur[gi][7:4], field_cur[gi][3:0] + 4'd1};
        end
      end
    end
  endgenerate

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: MODE is the only thing that moves the FSM.
  always_comb begin
    state_d = state_q;
    if (MODE) begin
      case (state_q)
        RUN:     state_d = SET_H;
        SET_H:   state_d = SET_M;
        SET_M:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // Output / datapath next values.
  always_comb begin
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    dayp_d = 1'b0;
    // Flags sample the current state, so they trail state changes by a cycle.
    blink_h_d = (state_q == SET_H) && SIG2HZ;
    blink_m_d = (state_q == SET_M) && SIG2HZ;

    case (state_q)
      RUN: begin
        if (MODE) begin
          // Entering set mode discards any coincident tick.
          sec_d = 8'h00;
        end else if (EN1HZ) begin
          sec_d = field_inc[0];
          if (field_wrap[0]) begin
            min_d = field_inc[1];
            if (field_wrap[1]) begin
              hour_d = field_inc[2];
              dayp_d = field_wrap[2];
            end
          end
        end
      end
      SET_H: begin
        sec_d = 8'h00;
        if (!MODE && UP) begin
          hour_d = field_inc[2];
        end
      end
      SET_M: begin
        sec_d = 8'h00;
        if (!MODE && UP) begin
          min_d = field_inc[1];
        end
      end
      default: begin
        sec_d = 8'h00;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sec_q     <= 8'h00;
      min_q     <= 8'h00;
      hour_q    <= 8'h00;
      blink_h_q <= 1'b0;
      blink_m_q <= 1'b0;
      dayp_q    <= 1'b0;
    end else begin
      sec_q     <= sec_d;
      min_q     <= min_d;
      hour_q    <= hour_d;
      blink_h_q <= blink_h_d;
      blink_m_q <= blink_m_d;
      dayp_q    <= dayp_d;
    end
  end

  assign SEC     = sec_q;
  assign MIN     = min_q;
  assign HOUR    = hour_q;
  assign BLINK_H = blink_h_q;
  assign BLINK_M = blink_m_q;
  assign DAYP    = dayp_q;

endmodule

// File: tb/tb_time_cnt24.sv
// tb_time_cnt24 -- drives a 24-hour and a 12-hour instance with the same
// stimulus and compares both against an integer time-of-day model.
module tb_time_cnt24;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN1HZ = 1'b0;
  logic       SIG2HZ = 1'b0;
  logic       MODE = 1'b0;
  logic       UP = 1'b0;

  logic [7:0] sec24, min24, hour24, sec12, min12, hour12;
  logic       bh24, bm24, dp24, bh12, bm12, dp12;

  time_cnt24 #(.HOURS_WRAP(24)) dut24 (
    .CLK(CLK), .RST(RST), .EN1HZ(EN1HZ), .SIG2HZ(SIG2HZ), .MODE(MODE), .UP(UP),
    .SEC(sec24), .MIN(min24), .HOUR(hour24),
    .BLINK_H(bh24), .BLINK_M(bm24), .DAYP(dp24)
  );

  time_cnt24 #(.HOURS_WRAP(12)) dut12 (
    .CLK(CLK), .RST(RST), .EN1HZ(EN1HZ), .SIG2HZ(SIG2HZ), .MODE(MODE), .UP(UP),
    .SEC(sec12), .MIN(min12), .HOUR(hour12),
    .BLINK_H(bh12), .BLINK_M(bm12), .DAYP(dp12)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: plain integers, state 0 = run, 1 = set hour, 2 = set minute.
  int hw[2] = '{24, 12};
  int m_h[2], m_m[2], m_s[2], m_st[2];
  bit m_bh[2], m_bm[2], m_dp[2];

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  function automatic logic [31:0] exp_vec(input int k);
    return {5'd0, bcd(m_h[k]), bcd(m_m[k]), bcd(m_s[k]), m_bh[k], m_bm[k], m_dp[k]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_update(input logic r, input logic e, input logic s,
                              input logic md, input logic u);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_h[k] = 0; m_m[k] = 0; m_s[k] = 0; m_st[k] = 0;
        m_bh[k] = 0; m_bm[k] = 0; m_dp[k] = 0;
      end else begin
        m_bh[k] = (m_st[k] == 1) && s;
        m_bm[k] = (m_st[k] == 2) && s;
        m_dp[k] = 0;
        if (md) begin
          if (m_st[k] == 0) m_s[k] = 0;
          m_st[k] = (m_st[k] + 1) % 3;
        end else if (m_st[k] == 0 && e) begin
          m_s[k]++;
          if (m_s[k] == 60) begin
            m_s[k] = 0;
            m_m[k]++;
            if (m_m[k] == 60) begin
              m_m[k] = 0;
              m_h[k]++;
              if (m_h[k] == hw[k]) begin
                m_h[k] = 0;
                m_dp[k] = 1;
              end
            end
          end
        end else if (m_st[k] == 1 && u) begin
          m_h[k] = (m_h[k] + 1) % hw[k];
        end else if (m_st[k] == 2 && u) begin
          m_m[k] = (m_m[k] + 1) % 60;
        end
      end
    end
  endtask

  // One clock of stimulus; the blink source toggles every four cycles.
  task automatic step(input logic r, input logic e, input logic md, input logic u);
    logic s;
    @(negedge CLK);
    s = ((cyc / 4) % 2) == 1;
    RST = r; EN1HZ = e; SIG2HZ = s; MODE = md; UP = u;
    @(posedge CLK);
    #1;
    cyc++;
    model_update(r, e, s, md, u);
    check("dut24", {5'd0, hour24, min24, sec24, bh24, bm24, dp24}, exp_vec(0));
    check("dut12", {5'd0, hour12, min12, sec12, bh12, bm12, dp12}, exp_vec(1));
    $display("cyc=%0d rst=%b en=%b sig=%b mode=%b up=%b | t24=%h:%h:%h b=%b%b d=%b | t12=%h:%h:%h b=%b%b d=%b",
             cyc, r, e, s, md, u, hour24, min24, sec24, bh24, bm24, dp24,
             hour12, min12, sec12, bh12, bm12, dp12);
  endtask

  task automatic pulses(input int n, input logic e, input logic md, input logic u);
    for (int i = 0; i < n; i++) begin
      step(1'b0, e, md, u);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    // Reset state.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("reset24", {5'd0, hour24, min24, sec24, bh24, bm24, dp24}, 32'd0);

    // One minute of ticks.
    pulses(60, 1'b1, 1'b0, 1'b0);
    check("min_after_60", {8'd0, hour24, min24, sec24}, 32'h0000_0100);

    // Set 23:59 (11:59 on the 12-hour part), run up to :58, then roll over.
    pulses(1, 1'b0, 1'b1, 1'b0);
    pulses(23, 1'b0, 1'b0, 1'b1);
    pulses(1, 1'b0, 1'b1, 1'b0);
    pulses(58, 1'b0, 1'b0, 1'b1);
    pulses(1, 1'b0, 1'b1, 1'b0);
    pulses(58, 1'b1, 1'b0, 1'b0);
    check("pre_roll24", {8'd0, hour24, min24, sec24}, 32'h0023_5958);
    check("pre_roll12", {8'd0, hour12, min12, sec12}, 32'h0011_5958);
    pulses(1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("roll24", {7'd0, dp24, hour24, min24, sec24}, 32'h0100_0000);
    check("roll12", {7'd0, dp12, hour12, min12, sec12}, 32'h0100_0000);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Reach 12:34:56, then exercise set mode.
    pulses(1, 1'b0, 1'b1, 1'b0);
    pulses(12, 1'b0, 1'b0, 1'b1);
    pulses(1, 1'b0, 1'b1, 1'b0);
    pulses(34, 1'b0, 1'b0, 1'b1);
    pulses(1, 1'b0, 1'b1, 1'b0);
    pulses(56, 1'b1, 1'b0, 1'b0);
    check("t123456", {8'd0, hour24, min24, sec24}, 32'h0012_3456);
    pulses(1, 1'b0, 1'b1, 1'b0);
    check("enter_set_sec", {24'd0, sec24}, 32'h0);
    for (int i = 0; i < 13; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b0);
    end
    check("hour_after_13up", {8'd0, hour24, min24, sec24}, 32'h0001_3400);
    pulses(1, 1'b0, 1'b1, 1'b0);
    pulses(24, 1'b0, 1'b0, 1'b1);
    pulses(3, 1'b0, 1'b0, 1'b1);
    check("min_wrap", {16'd0, hour24, min24}, 32'h0000_0101);
    pulses(1, 1'b0, 1'b1, 1'b0);
    check("blink_clear", {30'd0, bh24, bm24}, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("resume_sec", {24'd0, sec24}, 32'h01);

    // Corner pulses: MODE+EN1HZ at 10:00:59, MODE+UP at hour 05.
    pulses(1, 1'b0, 1'b1, 1'b0);
    pulses(9, 1'b0, 1'b0, 1'b1);
    pulses(1, 1'b0, 1'b1, 1'b0);
    pulses(59, 1'b0, 1'b0, 1'b1);
    pulses(1, 1'b0, 1'b1, 1'b0);
    pulses(59, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("mode_en", {8'd0, hour24, min24, sec24}, 32'h0010_0000);
    pulses(19, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("mode_up", {24'd0, hour24}, 32'h05);

    // Reset while blinking in minute-set.
    for (int i = 0; i < 16 && !m_bm[0]; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("blink_m_seen", {31'd0, bm24}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_midset", {5'd0, hour24, min24, sec24, bh24, bm24, dp24}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("after_rst_tick", {8'd0, hour24, min24, sec24}, 32'h0000_0001);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
